// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous data RAM between the
// CPU data port (port 0) and the loader/debug port (port 1). At most one
// access is granted per clock, and the grant is combinational. Read data
// comes back one cycle after the grant and is steered to the port that
// issued the read. stall0 tells the CPU to hold its pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall0,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic r_prio;     // port favoured on contention (round-robin only)
  logic r_resp_v;   // a read was granted last cycle
  logic r_resp_id;  // owner of that read

  logic w_win_v;
  logic w_win_id;
  logic w_win_we;

  // Winner selection; requests are ignored while reset is asserted.
  always_comb begin
    w_win_v  = (req0 | req1) & ~reset;
    w_win_id = 1'b0;
    if (req0 & req1)
      w_win_id = (RR != 0) ? r_prio : 1'b0;
    else
      w_win_id = req1;
    w_win_we = w_win_id ? we1 : we0;
  end

  // Grant, stall and memory-side drive. With no winner, the memory bus idles at zero.
  always_comb begin
    gnt0      = w_win_v & ~w_win_id;
    gnt1      = w_win_v &  w_win_id;
    stall0    = req0 & ~gnt0 & ~reset;
    mem_en    = w_win_v;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_win_v) begin
      mem_we    = w_win_we;
      mem_addr  = w_win_id ? addr1  : addr0;
      mem_wdata = w_win_id ? wdata1 : wdata0;
    end
  end

  // Priority rotation and read-response tracking; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio    <= 1'b0;
      r_resp_v  <= 1'b0;
      r_resp_id <= 1'b0;
    end else begin
      if ((RR != 0) && w_win_v)
        r_prio <= ~w_win_id;
      r_resp_v <= w_win_v & ~w_win_we;
      if (w_win_v & ~w_win_we)
        r_resp_id <= w_win_id;
    end
  end

  assign rvalid0 = r_resp_v & ~r_resp_id;
  assign rvalid1 = r_resp_v &  r_resp_id;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Instance h[0] uses round-robin and
// instance h[1] uses fixed priority. Each instance has its own RAM model and
// its own requesters, and each requester holds a request until it is granted.
// The stimulus pushes hand-computed expected grants and read responses. The
// per-instance monitors pop and compare those expectations on the falling edge.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : h
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, stall0, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic        s0, s1;
    acc_t        rq0[$];
    acc_t        rq1[$];
    gexp_t       eg[$];
    rexp_t       er[$];
    logic [31:0] mem [0:255];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .reset(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[16] = 32'hDEAD_BEEF;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      s0 = 1'b0; s1 = 1'b0;
    end

    // Synchronous RAM model with one-cycle read latency.
    always @(posedge clk) begin
      if (mem_en) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[7:0]];
      end
    end

    // Requesters: retire the head when it was granted, then present the next one.
    always @(posedge clk) begin
      acc_t a;
      if (s0 && rq0.size() != 0) void'(rq0.pop_front());
      if (s1 && rq1.size() != 0) void'(rq1.pop_front());
      #1;
      req0 = (rq0.size() != 0);
      a = req0 ? rq0[0] : '0;
      we0 = a.we; addr0 = a.addr; wdata0 = a.wdata;
      req1 = (rq1.size() != 0);
      a = req1 ? rq1[0] : '0;
      we1 = a.we; addr1 = a.addr; wdata1 = a.wdata;
    end

    // Monitor: compares grants, read responses, stall and reset behaviour.
    always @(negedge clk) begin
      gexp_t e;
      rexp_t r;
      logic  exp_stall;
      logic [31:0] got_d;
      s0 = gnt0;
      s1 = gnt1;
      exp_stall = !rst && req0 && !gnt0;
      checks++;
      if (stall0 !== exp_stall) begin
        errors++;
        $display("FAIL stall[%0d] t=%0t got %b want %b", g, $time, stall0, exp_stall);
      end
      if (rst) begin
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0) begin
          errors++;
          $display("FAIL reset_idle[%0d] t=%0t got gnt=%b%b en=%b we=%b want all 0",
                   g, $time, gnt0, gnt1, mem_en, mem_we);
        end
      end
      if (gnt0 || gnt1 || mem_en) begin
        checks++;
        if (eg.size() == 0) begin
          errors++;
          $display("FAIL grant[%0d] t=%0t got unexpected gnt=%b%b addr=%h want none",
                   g, $time, gnt0, gnt1, mem_addr);
        end else begin
          e = eg.pop_front();
          if ((gnt0 && gnt1) || gnt1 !== e.port || gnt0 !== !e.port || mem_en !== 1'b1 ||
              mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
            errors++;
            $display("FAIL grant[%0d] t=%0t got gnt=%b%b en=%b we=%b addr=%h wd=%h want port %0d we=%b addr=%h wd=%h",
                     g, $time, gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata,
                     e.port, e.we, e.addr, e.wdata);
          end
        end
      end
      if (rvalid0 || rvalid1) begin
        checks++;
        got_d = rvalid1 ? rdata1 : rdata0;
        if (er.size() == 0) begin
          errors++;
          $display("FAIL rdata[%0d] t=%0t got unexpected rvalid=%b%b want none",
                   g, $time, rvalid0, rvalid1);
        end else begin
          r = er.pop_front();
          if ((rvalid0 && rvalid1) || rvalid1 !== r.port || got_d !== r.data) begin
            errors++;
            $display("FAIL rdata[%0d] t=%0t got rvalid=%b%b data=%h want port %0d data=%h",
                     g, $time, rvalid0, rvalid1, got_d, r.port, r.data);
          end
        end
      end
    end
  end

  // Queue a request on a requester.
  task automatic req(input int inst, input bit port, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wd;
    if (inst == 0) begin
      if (port) h[0].rq1.push_back(a); else h[0].rq0.push_back(a);
    end else begin
      if (port) h[1].rq1.push_back(a); else h[1].rq0.push_back(a);
    end
  endtask

  // Expected grant, in the order the arbiter must issue it.
  task automatic expg(input int inst, input bit port, input bit we,
                      input logic [31:0] addr, input logic [31:0] wd);
    gexp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wd;
    if (inst == 0) h[0].eg.push_back(e); else h[1].eg.push_back(e);
  endtask

  // Expected read response.
  task automatic expr(input int inst, input bit port, input logic [31:0] d);
    rexp_t r;
    r.port = port; r.data = d;
    if (inst == 0) h[0].er.push_back(r); else h[1].er.push_back(r);
  endtask

  function automatic bit all_empty();
    return h[0].rq0.size() == 0 && h[0].rq1.size() == 0 && h[0].eg.size() == 0 &&
           h[0].er.size() == 0 && h[1].rq0.size() == 0 && h[1].rq1.size() == 0 &&
           h[1].eg.size() == 0 && h[1].er.size() == 0;
  endfunction

  // Wait for every outstanding expectation to be consumed, within a bound.
  task automatic drain(input string name);
    int n = 0;
    while (n < 60 && !all_empty()) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!all_empty()) begin
      errors++;
      $display("FAIL drain_%s got %0d/%0d/%0d/%0d pending want 0", name,
               h[0].eg.size() + h[1].eg.size(), h[0].er.size() + h[1].er.size(),
               h[0].rq0.size() + h[1].rq0.size(), h[0].rq1.size() + h[1].rq1.size());
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    // Both ports request throughout reset; nothing may be granted until release.
    rst = 1'b1;
    req(0, 0, 0, 32'h10, 0); req(0, 1, 0, 32'h11, 0);
    expg(0, 0, 0, 32'h10, 0); expg(0, 1, 0, 32'h11, 0);
    expr(0, 0, 32'hDEAD_BEEF); expr(0, 1, 32'hC0DE_0011);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    drain("reset");

    // Single read on port 0 (prio becomes 1).
    req(0, 0, 0, 32'h12, 0);
    expg(0, 0, 0, 32'h12, 0); expr(0, 0, 32'hC0DE_0012);
    drain("single");

    // Port 1 writes, then port 0 reads the same word back on the next cycle.
    req(0, 1, 1, 32'h20, 32'h1234_5678);
    expg(0, 1, 1, 32'h20, 32'h1234_5678);
    @(posedge clk); #2;
    req(0, 0, 0, 32'h20, 0);
    expg(0, 0, 0, 32'h20, 0); expr(0, 0, 32'h1234_5678);
    drain("wr_rd");

    // Port 1 read returns prio to 0.
    req(0, 1, 0, 32'h13, 0);
    expg(0, 1, 0, 32'h13, 0); expr(0, 1, 32'hC0DE_0013);
    drain("p1read");

    // Saturated contention: grants alternate starting with port 0.
    for (int i = 0; i < 4; i++) begin
      req(0, 0, 0, 32'h30 + i, 0);
      req(0, 1, 0, 32'h40 + i, 0);
    end
    for (int i = 0; i < 4; i++) begin
      expg(0, 0, 0, 32'h30 + i, 0); expr(0, 0, 32'hC0DE_0030 + i);
      expg(0, 1, 0, 32'h40 + i, 0); expr(0, 1, 32'hC0DE_0040 + i);
    end
    drain("contention");

    // Read granted, reset the next cycle: the response shows in the reset
    // cycle only, then contention must start at port 0 again.
    for (int p = 1; p >= 0; p--) begin
      req(0, p[0], 0, 32'h70 + p, 0);
      expg(0, p[0], 0, 32'h70 + p, 0); expr(0, p[0], 32'hC0DE_0070 + p);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      req(0, 0, 0, 32'h80 + 2 * p, 0); req(0, 1, 0, 32'h81 + 2 * p, 0);
      expg(0, 0, 0, 32'h80 + 2 * p, 0); expg(0, 1, 0, 32'h81 + 2 * p, 0);
      expr(0, 0, 32'hC0DE_0080 + 2 * p); expr(0, 1, 32'hC0DE_0081 + 2 * p);
      drain("midreset");
    end

    // Fixed priority: port 0 wins every cycle, port 1 is granted as soon as req0 drops.
    for (int i = 0; i < 6; i++) req(1, 0, 0, 32'h50 + i, 0);
    req(1, 1, 0, 32'h60, 0);
    for (int i = 0; i < 6; i++) begin
      expg(1, 0, 0, 32'h50 + i, 0); expr(1, 0, 32'hC0DE_0050 + i);
    end
    expg(1, 1, 0, 32'h60, 0); expr(1, 1, 32'hC0DE_0060);
    drain("fixed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
